// File: rtl/zap_wb_rr_arbiter_if.sv
// Bundle of requester-side and shared-bus Wishbone signals for the
// round-robin arbiter. The slave modport is the arbiter's view. The master
// modport is the environment's view: the requesters plus the system bus.
interface zap_wb_rr_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  // Requester side, one slice per port.
  logic [NUM_PORTS-1:0]    i_wb_cyc;
  logic [NUM_PORTS-1:0]    i_wb_stb;
  logic [NUM_PORTS-1:0]    i_wb_wen;
  logic [4*NUM_PORTS-1:0]  i_wb_sel;
  logic [32*NUM_PORTS-1:0] i_wb_dat;
  logic [32*NUM_PORTS-1:0] i_wb_adr;
  logic [3*NUM_PORTS-1:0]  i_wb_cti;
  logic [NUM_PORTS-1:0]    o_wb_ack;
  logic [NUM_PORTS-1:0]    o_wb_err;
  logic [NUM_PORTS-1:0]    o_grant;

  // Shared system bus side.
  logic                    o_wb_cyc;
  logic                    o_wb_stb;
  logic                    o_wb_wen;
  logic [3:0]              o_wb_sel;
  logic [31:0]             o_wb_dat;
  logic [31:0]             o_wb_adr;
  logic [2:0]              o_wb_cti;
  logic                    i_wb_ack;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_dat, i_wb_adr, i_wb_cti,
    input  i_wb_ack,
    output o_wb_ack, o_wb_err, o_grant,
    output o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_dat, i_wb_adr, i_wb_cti,
    output i_wb_ack,
    input  o_wb_ack, o_wb_err, o_grant,
    input  o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti
  );
endinterface

// File: rtl/zap_wb_rr_arbiter.sv
// Burst-aware round-robin Wishbone arbiter. It shares one system bus among
// NUM_PORTS requesters. Once a port holds the grant, it keeps it until an
// end-of-burst or classic ack, until it drops cyc, or until the bus times out.
// A single dead IDLE cycle always separates two tenures.
module zap_wb_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  zap_wb_rr_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_PORTS);
  // TIMEOUT=0 keeps a 1-bit counter that is tied to zero and optimises away.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0]    CTI_CLASSIC = 3'b000;
  localparam logic [2:0]    CTI_EOB     = 3'b111;
  localparam logic [IW-1:0] LAST_RST    = IW'(NUM_PORTS - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          state_ff;
  state_t          state_nx;
  logic [IW-1:0]   grant_ff;
  logic [IW-1:0]   grant_nx;
  logic [IW-1:0]   last_ff;
  logic [IW-1:0]   last_nx;
  logic [TW-1:0]   tmo_ff;
  logic [TW-1:0]   tmo_nx;

  logic [NUM_PORTS-1:0] req_s;
  logic [IW-1:0]        pick_s;
  logic                 found_s;

  logic        g_cyc_s;
  logic        g_stb_s;
  logic        g_wen_s;
  logic [3:0]  g_sel_s;
  logic [31:0] g_dat_s;
  logic [31:0] g_adr_s;
  logic [2:0]  g_cti_s;

  logic ack_end_s;
  logic tmo_hit_s;
  logic tmo_end_s;
  logic tenure_end_s;

  assign req_s = bus.i_wb_cyc & bus.i_wb_stb;

  // Find the first requester after the last owner, wrapping modulo NUM_PORTS.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    // Walk from the farthest candidate down to the nearest, so the nearest wins.
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (req_s[(int'(last_ff) + i) % NUM_PORTS]) begin
        found_s = 1'b1;
        pick_s  = IW'((int'(last_ff) + i) % NUM_PORTS);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Select the granted port's request signals.
  always_comb begin
    g_cyc_s = bus.i_wb_cyc[grant_ff];
    g_stb_s = bus.i_wb_stb[grant_ff];
    g_wen_s = bus.i_wb_wen[grant_ff];
    g_sel_s = bus.i_wb_sel[4*int'(grant_ff) +: 4];
    g_dat_s = bus.i_wb_dat[32*int'(grant_ff) +: 32];
    g_adr_s = bus.i_wb_adr[32*int'(grant_ff) +: 32];
    g_cti_s = bus.i_wb_cti[3*int'(grant_ff) +: 3];
  end

  // An ack wins over a timeout on the same cycle. A dropped cyc is a silent
  // abort, so it never raises err.
  assign ack_end_s    = bus.i_wb_ack &&
                        (!g_cyc_s || (g_cti_s == CTI_EOB) || (g_cti_s == CTI_CLASSIC));
  assign tmo_hit_s    = (TIMEOUT > 0) && g_stb_s && (tmo_ff == TMO_LAST);
  assign tmo_end_s    = g_cyc_s && !bus.i_wb_ack && tmo_hit_s;
  assign tenure_end_s = ack_end_s || !g_cyc_s || tmo_end_s;

  // State register: synchronous reset returns port 0 to top priority.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_ff <= S_IDLE;
      grant_ff <= '0;
      last_ff  <= LAST_RST;
      tmo_ff   <= '0;
    end else begin
      state_ff <= state_nx;
      grant_ff <= grant_nx;
      last_ff  <= last_nx;
      tmo_ff   <= (TIMEOUT > 0) ? tmo_nx : '0;
    end
  end

  // Next-state logic: arbitrate in IDLE, track tenure end and timeout in GRANT.
  always_comb begin
    state_nx = state_ff;
    grant_nx = grant_ff;
    last_nx  = last_ff;
    tmo_nx   = tmo_ff;
    case (state_ff)
      S_IDLE: begin
        tmo_nx = '0;
        if (found_s) begin
          state_nx = S_GRANT;
          grant_nx = pick_s;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_GRANT: begin
        if (tenure_end_s) begin
          state_nx = S_IDLE;
          last_nx  = grant_ff;
          tmo_nx   = '0;
        end else if (bus.i_wb_ack) begin
          tmo_nx = '0;
        end else if (g_stb_s) begin
          tmo_nx = tmo_ff + TW'(1);
        end else begin
          tmo_nx = tmo_ff;
        end
      end
      default: begin
        state_nx = S_IDLE;
        tmo_nx   = '0;
      end
    endcase
  end

  // Output logic: quiet bus in IDLE; in GRANT, mux the owner's signals and route ack/err.
  always_comb begin
    bus.o_wb_cyc = 1'b0;
    bus.o_wb_stb = 1'b0;
    bus.o_wb_wen = 1'b0;
    bus.o_wb_sel = 4'h0;
    bus.o_wb_dat = 32'h0;
    bus.o_wb_adr = 32'h0;
    bus.o_wb_cti = CTI_EOB;
    bus.o_wb_ack = '0;
    bus.o_wb_err = '0;
    bus.o_grant  = '0;
    case (state_ff)
      S_IDLE: begin
        bus.o_wb_cti = CTI_EOB;
      end
      S_GRANT: begin
        bus.o_wb_cyc           = g_cyc_s;
        bus.o_wb_stb           = g_stb_s;
        bus.o_wb_wen           = g_wen_s;
        bus.o_wb_sel           = g_sel_s;
        bus.o_wb_dat           = g_dat_s;
        bus.o_wb_adr           = g_adr_s;
        bus.o_wb_cti           = g_cti_s;
        bus.o_wb_ack[grant_ff] = bus.i_wb_ack;
        bus.o_wb_err[grant_ff] = tmo_end_s;
        bus.o_grant[grant_ff]  = 1'b1;
      end
      default: begin
        bus.o_wb_cti = CTI_EOB;
      end
    endcase
  end

endmodule

// File: tb/tb_zap_wb_rr_arbiter.sv
// Directed bench for zap_wb_rr_arbiter (4 ports, TIMEOUT=8). A behavioural
// owner/last/count model checks every output on every falling edge. Directed
// scenarios also check hand-computed grant sequences and bus values.
module tb_zap_wb_rr_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_BURST   = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  logic i_clk;
  logic i_reset;

  zap_wb_rr_arbiter_if #(.NUM_PORTS(N)) bus ();

  zap_wb_rr_arbiter #(.NUM_PORTS(N), .TIMEOUT(TMO)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Requester state: beats left per port; burst ports end with EOB, others with CLASSIC.
  int          beats   [N];
  logic        burst_r [N];
  logic        wen_r   [N];
  logic [3:0]  sel_r   [N];
  logic [31:0] dat_r   [N];
  logic [31:0] adr_r   [N];
  logic        ack_en;
  logic        ack_force;

  // Observations taken on the falling edge by step().
  logic [3:0]  obs_grant, obs_ack, obs_err, obs_sel;
  logic        obs_cyc, obs_stb, obs_wen;
  logic [31:0] obs_dat, obs_adr;
  logic [2:0]  obs_cti;

  // Slave device: acks every strobe while enabled, or unconditionally when forced.
  assign bus.i_wb_ack = ack_force | (ack_en & bus.o_wb_stb);

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      bus.i_wb_cyc[p]          = (beats[p] != 0);
      bus.i_wb_stb[p]          = (beats[p] != 0);
      bus.i_wb_wen[p]          = wen_r[p];
      bus.i_wb_sel[4*p +: 4]   = sel_r[p];
      bus.i_wb_dat[32*p +: 32] = dat_r[p];
      bus.i_wb_adr[32*p +: 32] = adr_r[p];
      bus.i_wb_cti[3*p +: 3]   = (beats[p] > 1) ? CTI_BURST :
                                 (burst_r[p] ? CTI_EOB : CTI_CLASSIC);
    end
  endtask

  // One cycle: sample outputs on the falling edge, then update requesters just after the rising edge.
  task automatic step();
    @(negedge i_clk);
    obs_grant = bus.o_grant;  obs_ack = bus.o_wb_ack; obs_err = bus.o_wb_err;
    obs_cyc   = bus.o_wb_cyc; obs_stb = bus.o_wb_stb; obs_wen = bus.o_wb_wen;
    obs_sel   = bus.o_wb_sel; obs_dat = bus.o_wb_dat; obs_adr = bus.o_wb_adr;
    obs_cti   = bus.o_wb_cti;
    @(posedge i_clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (obs_err[p]) beats[p] = 0;
      else if (obs_ack[p] && beats[p] > 0) beats[p] = beats[p] - 1;
    end
    drive();
  endtask

  // Expected grant sequence, one nibble per cycle, first cycle in the top nibble.
  task automatic expect_seq(input string name, input int n, input logic [63:0] s);
    for (int i = 0; i < n; i++) begin
      step();
      chk(name, 32'(obs_grant), 32'(s[4*(n-1-i) +: 4]));
    end
  endtask

  // Reference model: owner, last owner and wait count, checked every falling edge.
  int          m_owner, m_last, m_cnt;
  logic        m_busy, m_valid;
  logic        m_to, m_cyc, m_stb, m_ack;
  logic [2:0]  m_cti;
  logic [3:0]  e_grant, e_ack, e_err;
  initial begin
    m_valid = 1'b0; m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_cnt = 0;
    forever begin
      @(negedge i_clk);
      m_ack = bus.i_wb_ack;
      m_cyc = 1'b0; m_stb = 1'b0; m_cti = CTI_EOB; m_to = 1'b0;
      e_grant = 4'h0; e_ack = 4'h0; e_err = 4'h0;
      if (m_busy) begin
        m_cyc = bus.i_wb_cyc[m_owner];
        m_stb = bus.i_wb_stb[m_owner];
        m_cti = bus.i_wb_cti[3*m_owner +: 3];
        m_to  = (m_cnt == TMO - 1) && m_cyc && m_stb && !m_ack;
        e_grant[m_owner] = 1'b1;
        e_ack[m_owner]   = m_ack;
        e_err[m_owner]   = m_to;
      end
      if (m_valid) begin
        chk("m_grant", 32'(bus.o_grant),  32'(e_grant));
        chk("m_ack",   32'(bus.o_wb_ack), 32'(e_ack));
        chk("m_err",   32'(bus.o_wb_err), 32'(e_err));
        chk("m_cyc",   32'(bus.o_wb_cyc), 32'(m_cyc));
        chk("m_stb",   32'(bus.o_wb_stb), 32'(m_stb));
        chk("m_cti",   32'(bus.o_wb_cti), 32'(m_cti));
        chk("m_wen",   32'(bus.o_wb_wen), m_busy ? 32'(bus.i_wb_wen[m_owner]) : 32'h0);
        chk("m_sel",   32'(bus.o_wb_sel), m_busy ? 32'(bus.i_wb_sel[4*m_owner +: 4]) : 32'h0);
        chk("m_dat",   bus.o_wb_dat,      m_busy ? bus.i_wb_dat[32*m_owner +: 32] : 32'h0);
        chk("m_adr",   bus.o_wb_adr,      m_busy ? bus.i_wb_adr[32*m_owner +: 32] : 32'h0);
      end
      if (i_reset) begin
        m_busy = 1'b0; m_last = N - 1; m_cnt = 0; m_valid = 1'b1;
      end else if (m_valid && !m_busy) begin
        for (int k = 1; k <= N; k++) begin
          if (!m_busy && bus.i_wb_cyc[(m_last + k) % N] && bus.i_wb_stb[(m_last + k) % N]) begin
            m_busy = 1'b1; m_owner = (m_last + k) % N; m_cnt = 0;
          end
        end
      end else if (m_valid) begin
        if (m_ack) begin
          m_cnt = 0;
          if (!m_cyc || m_cti == CTI_EOB || m_cti == CTI_CLASSIC) begin
            m_busy = 1'b0; m_last = m_owner;
          end
        end else if (!m_cyc || m_to) begin
          m_busy = 1'b0; m_last = m_owner; m_cnt = 0;
        end else if (m_stb) begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected end of sequence", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1'b1; ack_en = 1'b0; ack_force = 1'b0;
    for (int p = 0; p < N; p++) begin
      beats[p] = 0; burst_r[p] = 1'b0; wen_r[p] = 1'b0; sel_r[p] = 4'hF;
      dat_r[p] = 32'hA000_0000 | 32'(p); adr_r[p] = 32'h0000_0100 * 32'(p + 1);
    end
    drive();

    // Reset state.
    step(); step();
    chk("rst_grant", 32'(obs_grant), 32'h0);
    chk("rst_cyc",   32'(obs_cyc),   32'h0);
    chk("rst_cti",   32'(obs_cti),   32'h7);
    chk("rst_ack",   32'(obs_ack),   32'h0);

    // All four ports request together: grants 0,1,2,3, one idle cycle between each.
    i_reset = 1'b0; ack_en = 1'b1;
    for (int p = 0; p < N; p++) beats[p] = 1;
    drive();
    expect_seq("rr_order", 9, 64'h0_1_0_2_0_4_0_8_0);

    // Port 1 4-beat burst holds the grant while port 0 waits.
    beats[1] = 4; burst_r[1] = 1'b1; drive();
    expect_seq("burst_idle", 1, 64'h0);
    beats[0] = 1; drive();
    expect_seq("burst_hold", 7, 64'h2_2_2_2_0_1_0);
    burst_r[1] = 1'b0;

    // Port 2 single write: bus mirrors the port's fields.
    ack_en = 1'b0; wen_r[2] = 1'b1; adr_r[2] = 32'h0000_1000; dat_r[2] = 32'hDEAD_BEEF;
    sel_r[2] = 4'hF; beats[2] = 1; drive();
    expect_seq("wr_idle", 1, 64'h0);
    step();
    chk("wr_grant", 32'(obs_grant), 32'h4);
    chk("wr_adr",   obs_adr,        32'h0000_1000);
    chk("wr_dat",   obs_dat,        32'hDEAD_BEEF);
    chk("wr_sel",   32'(obs_sel),   32'hF);
    chk("wr_wen",   32'(obs_wen),   32'h1);
    chk("wr_cti",   32'(obs_cti),   32'h0);
    chk("wr_noack", 32'(obs_ack),   32'h0);
    ack_en = 1'b1;
    step();
    chk("wr_ack", 32'(obs_ack), 32'h4);
    expect_seq("wr_done", 1, 64'h0);
    wen_r[2] = 1'b0;

    // Port 3 never acked: err pulses on the 8th granted cycle.
    ack_en = 1'b0; beats[3] = 1; drive();
    expect_seq("tmo_idle", 1, 64'h0);
    for (int i = 0; i < TMO; i++) begin
      step();
      chk("tmo_grant", 32'(obs_grant), 32'h8);
      chk("tmo_err",   32'(obs_err),   (i == TMO - 1) ? 32'h8 : 32'h0);
    end
    step();
    chk("tmo_after_grant", 32'(obs_grant), 32'h0);
    chk("tmo_after_err",   32'(obs_err),   32'h0);
    // last owner is now 3, so port 0 beats port 3.
    ack_en = 1'b1; beats[0] = 1; beats[3] = 1; drive();
    expect_seq("tmo_last", 5, 64'h0_1_0_8_0);

    // Port 0 burst aborted by cyc drop after 2 acks; port 1 is pending.
    beats[0] = 8; burst_r[0] = 1'b1; drive();
    expect_seq("abort_idle", 1, 64'h0);
    beats[1] = 1; drive();
    expect_seq("abort_beats", 2, 64'h1_1);
    beats[0] = 0; drive();
    step();
    chk("abort_grant", 32'(obs_grant), 32'h1);
    chk("abort_err",   32'(obs_err),   32'h0);
    expect_seq("abort_next", 3, 64'h0_2_0);
    burst_r[0] = 1'b0;

    // Reset during beat 2 of a port 2 burst.
    beats[2] = 4; burst_r[2] = 1'b1; drive();
    expect_seq("rstb_seq", 2, 64'h0_4);
    i_reset = 1'b1;
    step();
    chk("rstb_beat2_ack", 32'(obs_ack), 32'h4);
    ack_force = 1'b1;
    step();
    chk("rstb_cyc",   32'(obs_cyc),   32'h0);
    chk("rstb_grant", 32'(obs_grant), 32'h0);
    chk("rstb_ack",   32'(obs_ack),   32'h0);
    i_reset = 1'b0; ack_force = 1'b0;
    beats[2] = 0; burst_r[2] = 1'b0; beats[0] = 1; beats[3] = 1; drive();
    expect_seq("rstb_after", 5, 64'h0_1_0_8_0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
